coin_credit: RTL and testbench
==============================

# coin_credit

Payment front-end for the coffee vending machine. It takes debounced coin-slot and cancel levels, keeps a running credit in cents, and raises a vend request to the brew state machine when the credit covers the price. After the vend, or on cancel or timeout, it pays back any remaining credit as a train of change pulses. It sits between the button/coin debouncers and the brew state machine. Its credit output also drives the 7-segment controller.

## Interface
- PRICE, 50: cost of one cup in cents; must be a multiple of 5.
- CREDIT_W, 8: credit width; must satisfy 2^CREDIT_W > PRICE + 20.
- TIMEOUT_TICKS, 30: tick_1Hz strobes without a coin in COLLECT before an automatic refund.
- PULSE_CYC, 50_000_000: clocks high and clocks low of each change pulse.

Ports:
- clk_100MHz  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- tick_1Hz  in  1  one-cycle strobe, once per second.
- coin_nickel, coin_dime, coin_quarter  in  1 each  debounced slot levels; values 5/10/25.
- cancel  in  1  debounced cancel level.
- vend_ack  in  1  one-cycle pulse from the brew FSM when it accepts the vend.
- vend_req  out  1  held high in VEND.
- credit  out  CREDIT_W  current credit in cents.
- change_pulse  out  1  one pulse per 5 cents refunded.
- coin_reject  out  1  one-cycle pulse for each coin edge that is discarded.
- state  out  2  FSM state, for display.

## Operation
- Edge detection: rising edges on the coin inputs and on cancel. The history registers reset to 1, so an input already high when reset is released produces no edge.
- States: IDLE=0, COLLECT=1, VEND=2, REFUND=3.
- IDLE:
  - credit is 0.
  - On a coin edge, add the coin value and go to COLLECT.
  - A cancel edge is ignored.
- COLLECT:
  - A coin edge adds its value.
  - If credit ≥ PRICE, go to VEND on the next cycle.
  - A cancel edge goes to REFUND.
  - The timeout counter clears on every accepted coin and increments on each tick_1Hz. When it reaches TIMEOUT_TICKS, go to REFUND.
- VEND:
  - vend_req = 1.
  - Every coin edge is rejected; cancel is ignored.
  - On vend_ack, credit -= PRICE. If the result is > 0, go to REFUND; otherwise go to IDLE.
- REFUND:
  - Emit credit/5 pulses. Each pulse is high for PULSE_CYC cycles, then low for PULSE_CYC cycles.
  - credit -= 5 on each pulse's falling edge.
  - Go to IDLE when credit reaches 0 and the last low phase is complete.
  - Coin edges are rejected; cancel is ignored.
- Simultaneous coin edges in one cycle: only the highest value is accepted (quarter > dime > nickel). coin_reject pulses once for that cycle.
- Coin edge and cancel edge in the same COLLECT cycle: the coin is added and the state goes to REFUND, so the new coin is refunded too.
- Coin edge that brings credit ≥ PRICE in the same cycle as a cancel edge: cancel wins and the state goes to REFUND.
- Reset mid-operation, including mid-refund: all state is cleared and the unpaid credit is lost. Reset has priority over every input.

## Timing
- Reset values:
  - state IDLE
  - credit 0
  - vend_req 0
  - change_pulse 0
  - coin_reject 0
  - timeout counter 0
  - pulse counter 0
- A coin input first sampled high at edge n: credit is updated and visible after edge n+1.
- vend_req rises one cycle after credit first shows ≥ PRICE.
- vend_req falls in the cycle after vend_ack is sampled. credit shows the post-vend value at the same time.
- First change_pulse rises one cycle after entering REFUND.
- coin_reject goes high one cycle after the offending edge and lasts exactly one cycle.

## Structure
- Shared package coffee_pkg holds:
  - state encodings (IDLE/COLLECT/VEND/REFUND)
  - coin values 5/10/25
  - change unit 5
- One sub-module, rise_detect: a single-bit rising-edge detector with a history register that resets to 1. It is instanced four times.
- FSM, credit arithmetic, timeout counter and pulse timer all stay in coin_credit.

## Test plan
Run with PULSE_CYC=4 and TIMEOUT_TICKS=3.
- Two quarters → credit 25, then 50. vend_req rises the next cycle. vend_ack → credit 0, state IDLE, no change_pulse.
- Three dimes, then a quarter (55) → VEND. vend_ack → REFUND, exactly one pulse of 4 high + 4 low cycles. Then credit 0, state IDLE.
- Quarter + dime (35), then cancel → 7 change pulses. credit steps 35→30→…→0, then IDLE.
- Dime and nickel rising in the same cycle → credit 10, coin_reject pulses once. A nickel edge while in VEND → coin_reject pulses, credit unchanged.
- Quarter, then 3 tick_1Hz strobes with no coin → REFUND, 5 pulses, then IDLE.
- reset_n low during the 3rd pulse of a refund → next cycle credit 0, state IDLE, change_pulse 0. A coin level held high across reset release → no credit change.

Source files
------------

// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee vending machine payment path.
package coffee_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_REFUND  = 2'd3
    } state_e;

    localparam int unsigned NICKEL_CENTS  = 5;
    localparam int unsigned DIME_CENTS    = 10;
    localparam int unsigned QUARTER_CENTS = 25;
    localparam int unsigned CHANGE_UNIT   = 5;

endpackage

// File: rtl/coin_credit_rise_detect.sv
// Registered single-bit rising-edge detector; history resets high so a level
// already asserted at reset release is not reported as an edge.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic hist_q;
    logic rise_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hist_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            hist_q <= d_i;
            rise_q <= d_i & ~hist_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/coin_credit.sv
// Coin acceptor: accumulates credit, requests a vend at PRICE, and pays back
// leftover credit as a train of change pulses.
module coin_credit
    import coffee_pkg::*;
#(
    parameter int unsigned PRICE         = 50,
    parameter int unsigned CREDIT_W      = 8,
    parameter int unsigned TIMEOUT_TICKS = 30,
    parameter int unsigned PULSE_CYC     = 50_000_000
) (
    input  logic                clk_100MHz,
    input  logic                reset_n,
    input  logic                tick_1Hz,
    input  logic                coin_nickel,
    input  logic                coin_dime,
    input  logic                coin_quarter,
    input  logic                cancel,
    input  logic                vend_ack,
    output logic                vend_req,
    output logic [CREDIT_W-1:0] credit,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic [1:0]          state
);

    localparam int unsigned TMO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned PCNT_W = $clog2(2 * PULSE_CYC);

    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C    = CREDIT_W'(CHANGE_UNIT);
    localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT_TICKS - 1);
    localparam logic [PCNT_W-1:0]   PHASE_LOW = PCNT_W'(PULSE_CYC);
    localparam logic [PCNT_W-1:0]   PCNT_LAST = PCNT_W'(2 * PULSE_CYC - 1);

    logic nickel_rise, dime_rise, quarter_rise, cancel_rise;

    rise_detect u_rise_nickel  (.clk_i(clk_100MHz), .rst_ni(reset_n), .d_i(coin_nickel),  .rise_o(nickel_rise));
    rise_detect u_rise_dime    (.clk_i(clk_100MHz), .rst_ni(reset_n), .d_i(coin_dime),    .rise_o(dime_rise));
    rise_detect u_rise_quarter (.clk_i(clk_100MHz), .rst_ni(reset_n), .d_i(coin_quarter), .rise_o(quarter_rise));
    rise_detect u_rise_cancel  (.clk_i(clk_100MHz), .rst_ni(reset_n), .d_i(cancel),       .rise_o(cancel_rise));

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic                change_q, change_d;
    logic                reject_q, reject_d;

    logic                coin_any, coin_multi;
    logic [CREDIT_W-1:0] coin_val;

    always_comb begin
        coin_any   = nickel_rise | dime_rise | quarter_rise;
        coin_multi = (nickel_rise & dime_rise) | (nickel_rise & quarter_rise) | (dime_rise & quarter_rise);
        if (quarter_rise)     coin_val = CREDIT_W'(QUARTER_CENTS);
        else if (dime_rise)   coin_val = CREDIT_W'(DIME_CENTS);
        else if (nickel_rise) coin_val = CREDIT_W'(NICKEL_CENTS);
        else                  coin_val = '0;
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        tmo_d    = '0;
        pcnt_d   = '0;
        change_d = 1'b0;
        reject_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                credit_d = '0;
                reject_d = coin_multi;
                if (coin_any) begin
                    credit_d = coin_val;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                reject_d = coin_multi;
                tmo_d    = tmo_q;
                if (coin_any) begin
                    credit_d = credit_q + coin_val;
                    tmo_d    = '0;
                end else if (tick_1Hz) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                // Cancel outranks a completed price so a late coin is refunded too.
                if (cancel_rise)
                    state_d = ST_REFUND;
                else if (credit_q >= PRICE_C)
                    state_d = ST_VEND;
                else if (!coin_any && tick_1Hz && tmo_q == TMO_LAST)
                    state_d = ST_REFUND;
            end
            ST_VEND: begin
                reject_d = coin_any;
                if (vend_ack) begin
                    credit_d = credit_q - PRICE_C;
                    state_d  = (credit_q != PRICE_C) ? ST_REFUND : ST_IDLE;
                end
            end
            ST_REFUND: begin
                reject_d = coin_any;
                pcnt_d   = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_W'(1);
                change_d = (pcnt_q < PHASE_LOW);
                // The registered pulse falls on the edge where pcnt_q == PHASE_LOW.
                if (pcnt_q == PHASE_LOW)
                    credit_d = credit_q - UNIT_C;
                if (pcnt_q == PCNT_LAST && credit_q == '0)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            tmo_q    <= '0;
            pcnt_q   <= '0;
            change_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            tmo_q    <= tmo_d;
            pcnt_q   <= pcnt_d;
            change_q <= change_d;
            reject_q <= reject_d;
        end
    end

    assign vend_req     = (state_q == ST_VEND);
    assign credit       = credit_q;
    assign change_pulse = change_q;
    assign coin_reject  = reject_q;
    assign state        = state_q;

endmodule

// File: tb/tb_coin_credit.sv
// Directed bench for coin_credit with short pulse and timeout settings.
module tb_coin_credit;

    logic       clk_100MHz = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1Hz = 1'b0;
    logic       coin_nickel = 1'b0, coin_dime = 1'b0, coin_quarter = 1'b0;
    logic       cancel = 1'b0;
    logic       vend_ack = 1'b0;
    logic       vend_req;
    logic [7:0] credit;
    logic       change_pulse;
    logic       coin_reject;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;

    coin_credit #(
        .PRICE(50), .CREDIT_W(8), .TIMEOUT_TICKS(3), .PULSE_CYC(4)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .tick_1Hz(tick_1Hz),
        .coin_nickel(coin_nickel), .coin_dime(coin_dime), .coin_quarter(coin_quarter),
        .cancel(cancel), .vend_ack(vend_ack), .vend_req(vend_req), .credit(credit),
        .change_pulse(change_pulse), .coin_reject(coin_reject), .state(state)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic step(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    // 0 nickel, 1 dime, 2 quarter, 3 cancel: one-cycle level, then wait for the update.
    task automatic insert(input int kind);
        case (kind)
            0: coin_nickel = 1'b1;
            1: coin_dime = 1'b1;
            2: coin_quarter = 1'b1;
            default: cancel = 1'b1;
        endcase
        step(1);
        coin_nickel = 1'b0; coin_dime = 1'b0; coin_quarter = 1'b0; cancel = 1'b0;
        step(1);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(1);
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", state); end
        vectors++; if (credit !== 8'd0) begin miscompares++; $display("FAIL reset_credit got %0d exp 0", credit); end
        vectors++; if ({vend_req, change_pulse, coin_reject} !== 3'b000) begin miscompares++; $display("FAIL reset_outs got %b exp 000", {vend_req, change_pulse, coin_reject}); end
        insert(3);
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL idle_cancel state got %0d exp 0", state); end
    endtask

    task automatic test_vend_exact;
        int hi;
        insert(2);
        vectors++; if (credit !== 8'd25 || state !== 2'd1) begin miscompares++; $display("FAIL q1 credit/state got %0d/%0d exp 25/1", credit, state); end
        insert(2);
        vectors++; if (credit !== 8'd50 || vend_req !== 1'b0) begin miscompares++; $display("FAIL q2 credit/vend_req got %0d/%0d exp 50/0", credit, vend_req); end
        step(1);
        vectors++; if (vend_req !== 1'b1 || state !== 2'd2) begin miscompares++; $display("FAIL vend_rise vend_req/state got %0d/%0d exp 1/2", vend_req, state); end
        vend_ack = 1'b1; step(1); vend_ack = 1'b0;
        vectors++; if (credit !== 8'd0 || state !== 2'd0 || vend_req !== 1'b0) begin miscompares++; $display("FAIL vend_exact credit/state/req got %0d/%0d/%0d exp 0/0/0", credit, state, vend_req); end
        hi = 0;
        for (int i = 0; i < 10; i++) begin step(1); if (change_pulse) hi++; end
        vectors++; if (hi !== 0) begin miscompares++; $display("FAIL vend_exact_nochange got %0d high cycles exp 0", hi); end
    endtask

    task automatic test_vend_change;
        int hi;
        insert(1); insert(1); insert(1);
        vectors++; if (credit !== 8'd30) begin miscompares++; $display("FAIL three_dimes credit got %0d exp 30", credit); end
        insert(2);
        vectors++; if (credit !== 8'd55 || vend_req !== 1'b0) begin miscompares++; $display("FAIL dq credit/req got %0d/%0d exp 55/0", credit, vend_req); end
        step(1);
        vectors++; if (vend_req !== 1'b1) begin miscompares++; $display("FAIL vend55_req got %0d exp 1", vend_req); end
        vend_ack = 1'b1; step(1); vend_ack = 1'b0;
        vectors++; if (credit !== 8'd5 || state !== 2'd3 || change_pulse !== 1'b0) begin miscompares++; $display("FAIL vend55_ack credit/state/pulse got %0d/%0d/%0d exp 5/3/0", credit, state, change_pulse); end
        hi = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (change_pulse) hi++;
            if (i <= 4 && change_pulse !== 1'b1) begin vectors++; miscompares++; $display("FAIL change_high cycle %0d got 0 exp 1", i); end
            if (i == 5) begin vectors++; if (credit !== 8'd0 || change_pulse !== 1'b0) begin miscompares++; $display("FAIL change_fall credit/pulse got %0d/%0d exp 0/0", credit, change_pulse); end end
            if (i == 7) begin vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL low_phase_state got %0d exp 3", state); end end
        end
        vectors++; if (hi !== 4) begin miscompares++; $display("FAIL change_width got %0d exp 4", hi); end
        vectors++; if (state !== 2'd0 || credit !== 8'd0) begin miscompares++; $display("FAIL refund_done state/credit got %0d/%0d exp 0/0", state, credit); end
    endtask

    task automatic test_cancel_refund;
        int pulses, cyc;
        logic prev;
        insert(2); insert(1);
        vectors++; if (credit !== 8'd35) begin miscompares++; $display("FAIL qd credit got %0d exp 35", credit); end
        insert(3);
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL cancel_state got %0d exp 3", state); end
        pulses = 0; cyc = 0; prev = 1'b0;
        while (state !== 2'd0 && cyc < 200) begin
            step(1); cyc++;
            if (change_pulse && !prev) pulses++;
            if (!change_pulse && prev) begin
                vectors++;
                if (int'(credit) !== 35 - 5 * pulses) begin miscompares++; $display("FAIL refund_step got %0d exp %0d", credit, 35 - 5 * pulses); end
            end
            prev = change_pulse;
        end
        vectors++; if (cyc >= 200) begin miscompares++; $display("FAIL cancel_refund_timeout got %0d cycles exp <200", cyc); end
        vectors++; if (pulses !== 7 || credit !== 8'd0) begin miscompares++; $display("FAIL cancel_pulses/credit got %0d/%0d exp 7/0", pulses, credit); end
    endtask

    task automatic test_reject;
        coin_dime = 1'b1; coin_nickel = 1'b1;
        step(1);
        coin_dime = 1'b0; coin_nickel = 1'b0;
        step(1);
        vectors++; if (credit !== 8'd10 || coin_reject !== 1'b1) begin miscompares++; $display("FAIL simul credit/reject got %0d/%0d exp 10/1", credit, coin_reject); end
        step(1);
        vectors++; if (coin_reject !== 1'b0) begin miscompares++; $display("FAIL simul_reject_len got %0d exp 0", coin_reject); end
        insert(2); insert(1); insert(0);
        vectors++; if (credit !== 8'd50 || coin_reject !== 1'b0) begin miscompares++; $display("FAIL to50 credit/reject got %0d/%0d exp 50/0", credit, coin_reject); end
        step(1);
        insert(0);
        vectors++; if (coin_reject !== 1'b1 || credit !== 8'd50 || state !== 2'd2) begin miscompares++; $display("FAIL vend_reject reject/credit/state got %0d/%0d/%0d exp 1/50/2", coin_reject, credit, state); end
        step(1);
        vectors++; if (coin_reject !== 1'b0) begin miscompares++; $display("FAIL vend_reject_len got %0d exp 0", coin_reject); end
        vend_ack = 1'b1; step(1); vend_ack = 1'b0;
        vectors++; if (state !== 2'd0 || credit !== 8'd0) begin miscompares++; $display("FAIL reject_vend state/credit got %0d/%0d exp 0/0", state, credit); end
    endtask

    task automatic test_timeout;
        int pulses, cyc;
        logic prev;
        insert(2);
        for (int t = 0; t < 2; t++) begin tick_1Hz = 1'b1; step(1); tick_1Hz = 1'b0; step(1); end
        vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL two_ticks state got %0d exp 1", state); end
        tick_1Hz = 1'b1; step(1); tick_1Hz = 1'b0;
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL timeout state got %0d exp 3", state); end
        pulses = 0; cyc = 0; prev = 1'b0;
        while (state !== 2'd0 && cyc < 200) begin
            step(1); cyc++;
            if (change_pulse && !prev) pulses++;
            prev = change_pulse;
        end
        vectors++; if (cyc >= 200 || pulses !== 5 || credit !== 8'd0) begin miscompares++; $display("FAIL timeout_refund pulses/credit/cyc got %0d/%0d/%0d exp 5/0/<200", pulses, credit, cyc); end
    endtask

    task automatic test_coin_cancel;
        int pulses, cyc;
        logic prev;
        insert(1);
        coin_nickel = 1'b1; cancel = 1'b1;
        step(1);
        coin_nickel = 1'b0; cancel = 1'b0;
        step(1);
        vectors++; if (state !== 2'd3 || credit !== 8'd15) begin miscompares++; $display("FAIL coin_cancel state/credit got %0d/%0d exp 3/15", state, credit); end
        pulses = 0; cyc = 0; prev = 1'b0;
        while (state !== 2'd0 && cyc < 200) begin
            step(1); cyc++;
            if (change_pulse && !prev) pulses++;
            prev = change_pulse;
        end
        vectors++; if (cyc >= 200 || pulses !== 3) begin miscompares++; $display("FAIL coin_cancel_pulses got %0d cyc %0d exp 3", pulses, cyc); end
    endtask

    task automatic test_reset_midrefund;
        int pulses, cyc;
        logic prev;
        insert(2); insert(1); insert(3);
        pulses = 0; cyc = 0; prev = 1'b0;
        while (pulses < 3 && cyc < 200) begin
            step(1); cyc++;
            if (change_pulse && !prev) pulses++;
            prev = change_pulse;
        end
        vectors++; if (pulses !== 3 || credit !== 8'd25) begin miscompares++; $display("FAIL third_pulse pulses/credit got %0d/%0d exp 3/25", pulses, credit); end
        reset_n = 1'b0; coin_quarter = 1'b1;
        step(1);
        vectors++; if (credit !== 8'd0 || state !== 2'd0 || change_pulse !== 1'b0) begin miscompares++; $display("FAIL midreset credit/state/pulse got %0d/%0d/%0d exp 0/0/0", credit, state, change_pulse); end
        step(2);
        reset_n = 1'b1;
        step(4);
        vectors++; if (credit !== 8'd0 || state !== 2'd0 || coin_reject !== 1'b0) begin miscompares++; $display("FAIL held_coin credit/state/reject got %0d/%0d/%0d exp 0/0/0", credit, state, coin_reject); end
        coin_quarter = 1'b0;
        step(3);
        vectors++; if (credit !== 8'd0) begin miscompares++; $display("FAIL held_coin_release credit got %0d exp 0", credit); end
    endtask

    initial begin
        test_reset();
        test_vend_exact();
        test_vend_change();
        test_cancel_refund();
        test_reject();
        test_timeout();
        test_coin_cancel();
        test_reset_midrefund();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
